// File: rtl/timer_scheduler_if.sv
// Event delivery port of timer_scheduler: valid/ready handshake carrying the expired channel id.
interface timer_scheduler_if #(
  parameter int N_CH = 4
);
  localparam int ID_W = $clog2(N_CH);

  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic            evt_ready;

  modport master (output evt_valid, output evt_id, input evt_ready);
  modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/timer_scheduler.sv
// Multi-channel periodic event scheduler: shared prescaler, per-channel tick counters, round-robin delivery.
// Optional sticky per-channel overrun flags are built when TIMER_SCHED_OVERRUN_EN is defined.
module timer_scheduler #(
  parameter int  N_CH  = 4,
  parameter int  CNT_W = 16,
  parameter int  PRE_W = 16,
  localparam int ID_W  = $clog2(N_CH)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               ena_i,
  input  logic [PRE_W-1:0]   prescale_i,
  input  logic               cfg_we_i,
  input  logic [ID_W-1:0]    cfg_ch_i,
  input  logic               cfg_en_i,
  input  logic [CNT_W-1:0]   cfg_period_i,
  output logic               tick_o,
  timer_scheduler_if.master  evt
`ifdef TIMER_SCHED_OVERRUN_EN
  ,
  output logic [N_CH-1:0]    overrun_o
`endif
);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic [CNT_W-1:0] cnt    [N_CH];
  logic [CNT_W-1:0] period [N_CH];
  logic [N_CH-1:0]  en;
  logic [N_CH-1:0]  pending;
  logic [N_CH-1:0]  expire;
  logic [N_CH-1:0]  cfg_hit;
  logic [N_CH-1:0]  hs_clr;
  logic [N_CH-1:0]  cand;
  logic             hs;
  logic             valid_q;
  logic [ID_W-1:0]  gnt_q;
  logic [ID_W-1:0]  ptr_q;
  logic             found;
  logic [ID_W-1:0]  pick;
  logic [ID_W-1:0]  scan;

  // Reset gating keeps tick_o low during reset even when prescale_i is 0.
  assign tick   = rst_ni & ena_i & (pre_cnt >= prescale_i);
  assign tick_o = tick;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_cnt <= '0;
    end else if (ena_i) begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
    end
  end

  assign hs = valid_q & evt.evt_ready;

  always_comb begin
    expire  = '0;
    cfg_hit = '0;
    hs_clr  = '0;
    for (int k = 0; k < N_CH; k++) begin
      cfg_hit[k] = cfg_we_i && (cfg_ch_i == ID_W'(k));
      expire[k]  = tick && en[k] && (period[k] != '0) && (cnt[k] == period[k] - CNT_W'(1));
      hs_clr[k]  = hs && (gnt_q == ID_W'(k));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en      <= '0;
      pending <= '0;
      for (int k = 0; k < N_CH; k++) begin
        cnt[k]    <= '0;
        period[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (cfg_hit[k]) begin
          period[k]  <= cfg_period_i;
          en[k]      <= cfg_en_i;
          cnt[k]     <= '0;
          pending[k] <= 1'b0;
        end else begin
          if (tick && en[k] && (period[k] != '0)) begin
            cnt[k] <= expire[k] ? '0 : cnt[k] + CNT_W'(1);
          end
          // A re-expiry in the handshake cycle wins, so the new event survives the clear.
          if (expire[k]) begin
            pending[k] <= 1'b1;
          end else if (hs_clr[k]) begin
            pending[k] <= 1'b0;
          end
        end
      end
    end
  end

`ifdef TIMER_SCHED_OVERRUN_EN
  logic [N_CH-1:0] overrun;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overrun <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (cfg_hit[k]) begin
          overrun[k] <= 1'b0;
        end else if (expire[k] && pending[k] && !hs_clr[k]) begin
          overrun[k] <= 1'b1;
        end
      end
    end
  end

  assign overrun_o = overrun;
`endif

  // Channels being consumed or reconfigured this cycle must not be re-offered from stale pending bits.
  always_comb begin
    cand  = pending & ~hs_clr & ~cfg_hit;
    found = 1'b0;
    pick  = '0;
    scan  = '0;
    for (int i = 1; i <= N_CH; i++) begin
      scan = ID_W'((int'(ptr_q) + i) % N_CH);
      if (!found && cand[scan]) begin
        found = 1'b1;
        pick  = scan;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      gnt_q   <= '0;
      ptr_q   <= ID_W'(N_CH - 1);
    end else if (!valid_q || hs) begin
      valid_q <= found;
      if (found) begin
        gnt_q <= pick;
        ptr_q <= pick;
      end
    end else if (cfg_hit[gnt_q]) begin
      valid_q <= 1'b0;
    end
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_id    = gnt_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed self-checking bench for timer_scheduler; inputs change and outputs are sampled on negedge.
module tb_timer_scheduler;
  localparam int N_CH  = 4;
  localparam int CNT_W = 16;
  localparam int PRE_W = 16;
  localparam int ID_W  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena = 1'b0;
  logic [PRE_W-1:0] prescale = '0;
  logic             cfg_we = 1'b0;
  logic [ID_W-1:0]  cfg_ch = '0;
  logic             cfg_en = 1'b0;
  logic [CNT_W-1:0] cfg_period = '0;
  logic             tick;
`ifdef TIMER_SCHED_OVERRUN_EN
  logic [N_CH-1:0]  overrun;
`endif
  int checks = 0;
  int failures = 0;

  timer_scheduler_if #(.N_CH(N_CH)) evt_bus ();

  timer_scheduler #(.N_CH(N_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ena_i        (ena),
    .prescale_i   (prescale),
    .cfg_we_i     (cfg_we),
    .cfg_ch_i     (cfg_ch),
    .cfg_en_i     (cfg_en),
    .cfg_period_i (cfg_period),
    .tick_o       (tick),
    .evt          (evt_bus)
`ifdef TIMER_SCHED_OVERRUN_EN
    ,
    .overrun_o    (overrun)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ena = 1'b0; cfg_we = 1'b0; evt_bus.evt_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic cfg_write(input int ch, input bit en_v, input int per);
    cfg_ch = ID_W'(ch); cfg_en = en_v; cfg_period = CNT_W'(per); cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; prescale = '0; evt_bus.evt_ready = 1'b0;
    step();
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick: got %0b expected 0", tick); end
    checks++; if (evt_bus.evt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", evt_bus.evt_valid); end
    checks++; if (evt_bus.evt_id !== 2'd0) begin failures++; $display("FAIL reset_id: got %0d expected 0", evt_bus.evt_id); end
`ifdef TIMER_SCHED_OVERRUN_EN
    checks++; if (overrun !== 4'b0) begin failures++; $display("FAIL reset_overrun: got %b expected 0000", overrun); end
`endif
    ena = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    checks++; if (evt_bus.evt_valid !== 1'b0) begin failures++; $display("FAIL post_reset_valid: got %0b expected 0", evt_bus.evt_valid); end
  endtask

  task automatic test_periodic();
    logic exp_tick, exp_valid;
    do_reset();
    prescale = PRE_W'(3);
    cfg_write(0, 1'b1, 2);
    evt_bus.evt_ready = 1'b1;
    ena = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      step();
      exp_tick  = (k % 4 == 3);
      exp_valid = (k >= 9) && (k % 8 == 1);
      checks++; if (tick !== exp_tick) begin failures++; $display("FAIL periodic_tick k=%0d: got %0b expected %0b", k, tick, exp_tick); end
      checks++; if (evt_bus.evt_valid !== exp_valid) begin failures++; $display("FAIL periodic_valid k=%0d: got %0b expected %0b", k, evt_bus.evt_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (evt_bus.evt_id !== 2'd0) begin failures++; $display("FAIL periodic_id k=%0d: got %0d expected 0", k, evt_bus.evt_id); end
      end
    end
    ena = 1'b0;
  endtask

  task automatic test_round_robin();
    do_reset();
    prescale = '0;
    for (int c = 0; c < N_CH; c++) cfg_write(c, 1'b1, 1);
    evt_bus.evt_ready = 1'b0;
    ena = 1'b1;
    step(); step();
    for (int i = 0; i < 20; i++) begin
      checks++; if (evt_bus.evt_valid !== 1'b1) begin failures++; $display("FAIL stall_valid i=%0d: got %0b expected 1", i, evt_bus.evt_valid); end
      checks++; if (evt_bus.evt_id !== 2'd0) begin failures++; $display("FAIL stall_id i=%0d: got %0d expected 0", i, evt_bus.evt_id); end
      step();
    end
    evt_bus.evt_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      checks++; if (evt_bus.evt_valid !== 1'b1) begin failures++; $display("FAIL rr_valid i=%0d: got %0b expected 1", i, evt_bus.evt_valid); end
      checks++; if (evt_bus.evt_id !== ID_W'(i % 4)) begin failures++; $display("FAIL rr_id i=%0d: got %0d expected %0d", i, evt_bus.evt_id, i % 4); end
      step();
    end
    evt_bus.evt_ready = 1'b0;
    ena = 1'b0;
  endtask

`ifdef TIMER_SCHED_OVERRUN_EN
  task automatic test_overrun();
    logic [N_CH-1:0] exp_ovr;
    do_reset();
    prescale = PRE_W'(3);
    cfg_write(1, 1'b1, 1);
    evt_bus.evt_ready = 1'b0;
    ena = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_ovr = (k >= 8) ? 4'b0010 : 4'b0000;
      checks++; if (overrun !== exp_ovr) begin failures++; $display("FAIL overrun_set k=%0d: got %b expected %b", k, overrun, exp_ovr); end
    end
    checks++; if (evt_bus.evt_valid !== 1'b1 || evt_bus.evt_id !== 2'd1) begin failures++; $display("FAIL overrun_offer: got valid=%0b id=%0d expected valid=1 id=1", evt_bus.evt_valid, evt_bus.evt_id); end
    cfg_write(1, 1'b1, 1);
    checks++; if (overrun !== 4'b0000) begin failures++; $display("FAIL overrun_clear: got %b expected 0000", overrun); end
    checks++; if (evt_bus.evt_valid !== 1'b0) begin failures++; $display("FAIL overrun_withdraw: got %0b expected 0", evt_bus.evt_valid); end
    step();
    checks++; if (evt_bus.evt_valid !== 1'b0) begin failures++; $display("FAIL overrun_pending_clear: got %0b expected 0", evt_bus.evt_valid); end
    ena = 1'b0;
  endtask
`endif

  task automatic test_cfg_collision();
    logic exp_valid;
    do_reset();
    prescale = PRE_W'(3);
    cfg_write(2, 1'b1, 2);
    evt_bus.evt_ready = 1'b1;
    ena = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step();
      exp_valid = (k == 17);
      checks++; if (evt_bus.evt_valid !== exp_valid) begin failures++; $display("FAIL collide_valid k=%0d: got %0b expected %0b", k, evt_bus.evt_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (evt_bus.evt_id !== 2'd2) begin failures++; $display("FAIL collide_id: got %0d expected 2", evt_bus.evt_id); end
      end
      cfg_we = 1'b0;
      if (k == 7) begin
        cfg_ch = 2'd2; cfg_en = 1'b1; cfg_period = CNT_W'(2); cfg_we = 1'b1;
      end
    end
    ena = 1'b0;
  endtask

  task automatic test_enable_freeze();
    logic exp_tick, exp_valid;
    do_reset();
    prescale = PRE_W'(3);
    cfg_write(0, 1'b1, 2);
    evt_bus.evt_ready = 1'b0;
    ena = 1'b1;
    for (int k = 1; k <= 9; k++) step();
    checks++; if (evt_bus.evt_valid !== 1'b1) begin failures++; $display("FAIL freeze_pre_valid: got %0b expected 1", evt_bus.evt_valid); end
    ena = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      step();
      checks++; if (tick !== 1'b0) begin failures++; $display("FAIL freeze_tick j=%0d: got %0b expected 0", j, tick); end
      checks++; if (evt_bus.evt_valid !== 1'b1 || evt_bus.evt_id !== 2'd0) begin failures++; $display("FAIL freeze_hold j=%0d: got valid=%0b id=%0d expected valid=1 id=0", j, evt_bus.evt_valid, evt_bus.evt_id); end
    end
    evt_bus.evt_ready = 1'b1;
    step();
    checks++; if (evt_bus.evt_valid !== 1'b0) begin failures++; $display("FAIL freeze_delivered: got %0b expected 0", evt_bus.evt_valid); end
    ena = 1'b1;
    for (int m = 1; m <= 8; m++) begin
      step();
      exp_tick  = (m == 2) || (m == 6);
      exp_valid = (m == 8);
      checks++; if (tick !== exp_tick) begin failures++; $display("FAIL resume_tick m=%0d: got %0b expected %0b", m, tick, exp_tick); end
      checks++; if (evt_bus.evt_valid !== exp_valid) begin failures++; $display("FAIL resume_valid m=%0d: got %0b expected %0b", m, evt_bus.evt_valid, exp_valid); end
    end
    ena = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    prescale = '0;
    for (int c = 0; c < N_CH; c++) cfg_write(c, 1'b1, 1);
    evt_bus.evt_ready = 1'b1;
    ena = 1'b1;
    for (int k = 0; k < 5; k++) step();
    checks++; if (evt_bus.evt_valid !== 1'b1) begin failures++; $display("FAIL midrst_pre_valid: got %0b expected 1", evt_bus.evt_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (evt_bus.evt_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %0b expected 0", evt_bus.evt_valid); end
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL midrst_tick: got %0b expected 0", tick); end
    checks++; if (evt_bus.evt_id !== 2'd0) begin failures++; $display("FAIL midrst_id: got %0d expected 0", evt_bus.evt_id); end
`ifdef TIMER_SCHED_OVERRUN_EN
    checks++; if (overrun !== 4'b0) begin failures++; $display("FAIL midrst_overrun: got %b expected 0000", overrun); end
`endif
    step();
    ena = 1'b0; evt_bus.evt_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int c = 0; c < N_CH; c++) cfg_write(c, 1'b1, 1);
    ena = 1'b1;
    step(); step();
    checks++; if (evt_bus.evt_valid !== 1'b1 || evt_bus.evt_id !== 2'd0) begin failures++; $display("FAIL midrst_first_grant: got valid=%0b id=%0d expected valid=1 id=0", evt_bus.evt_valid, evt_bus.evt_id); end
    ena = 1'b0;
  endtask

  initial begin
    evt_bus.evt_ready = 1'b0;
    test_reset();
    test_periodic();
    test_round_robin();
`ifdef TIMER_SCHED_OVERRUN_EN
    test_overrun();
`endif
    test_cfg_collision();
    test_enable_freeze();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
